// File: rtl/div_pkg.sv
// Shared types and defaults for the divider-result BCD converter.
package div_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        CONV_Q,
        CONV_A,
        DONE
    } bcd_state_t;

    // Decimal digits needed to hold 2**width - 1.
    function automatic int bcd_digits(input int width);
        int     n;
        longint m;
        n = 1;
        m = (longint'(1) << width) - 1;
        while (m >= 10) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift in one bit.
module bcd_dd_step #(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] digits,
    input  logic                bit_next,
    output logic [4*DIGITS-1:0] shifted
);

    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[4*DIGITS-2:0], bit_next};
    end

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider quotient/remainder on a ready edge and converts them to BCD.
// Remainder conversion is enabled by defining DIV_REM_BCD_EN.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_ready,
    input  logic [WIDTH-1:0]    Qbus_in,
    input  logic [WIDTH-1:0]    Abus_in,
    output logic [4*DIGITS-1:0] Qbcd_out,
    output logic [4*DIGITS-1:0] Abcd_out,
    output logic                valid,
    output logic                busy,
    output logic                overrun
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    bcd_state_t state, state_nx;

    logic          ready_d;
    logic          rise;
    logic [CW-1:0] cnt;
    logic          last;
    logic [WIDTH-1:0] q_sh;
    logic [BW-1:0] acc;
    logic [BW-1:0] acc_nx;
    logic [BW-1:0] q_final;
    logic          accept;
    logic          ignore;
    logic          step;
    logic          hand_off;
    logic          op_bit;

    assign rise = div_ready & ~ready_d;
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (rise) state_nx = CONV_Q;
`ifdef DIV_REM_BCD_EN
            CONV_Q:  if (last) state_nx = CONV_A;
            CONV_A:  if (last) state_nx = DONE;
`else
            CONV_Q:  if (last) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Any edge outside IDLE, including the DONE cycle, is dropped as an overrun.
    always_comb begin
        accept = (state == IDLE) && rise;
        ignore = (state != IDLE) && rise;
        step   = (state == CONV_Q) || (state == CONV_A);
`ifdef DIV_REM_BCD_EN
        hand_off = (state == CONV_Q) && last;
`else
        hand_off = 1'b0;
`endif
    end

    bcd_dd_step #(
        .DIGITS(DIGITS)
    ) u_step (
        .digits   (acc),
        .bit_next (op_bit),
        .shifted  (acc_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_d  <= 1'b1;
            cnt      <= '0;
            q_sh     <= '0;
            acc      <= '0;
            Qbcd_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ready_d <= div_ready;
            if (ignore) begin
                overrun <= 1'b1;
            end
            if (accept) begin
                q_sh  <= Qbus_in;
                acc   <= '0;
                cnt   <= '0;
                valid <= 1'b0;
                busy  <= 1'b1;
            end
            if (step) begin
                acc <= hand_off ? '0 : acc_nx;
                cnt <= last ? '0 : cnt + 1'b1;
                if (state == CONV_Q) begin
                    q_sh <= {q_sh[WIDTH-2:0], 1'b0};
                end
            end
            if (state == DONE) begin
                Qbcd_out <= q_final;
                valid    <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

`ifdef DIV_REM_BCD_EN
    logic [WIDTH-1:0] a_sh;
    logic [BW-1:0]    q_hold;

    assign op_bit  = (state == CONV_A) ? a_sh[WIDTH-1] : q_sh[WIDTH-1];
    assign q_final = q_hold;

    // Quotient digits park in q_hold while the shared engine runs the remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            q_hold   <= '0;
            Abcd_out <= '0;
        end else begin
            if (accept) begin
                a_sh <= Abus_in;
            end
            if (state == CONV_A) begin
                a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            end
            if (hand_off) begin
                q_hold <= acc_nx;
            end
            if (state == DONE) begin
                Abcd_out <= acc;
            end
        end
    end
`else
    logic unused_abus;

    assign op_bit      = q_sh[WIDTH-1];
    assign q_final     = acc;
    assign Abcd_out    = '0;
    assign unused_abus = ^Abus_in;
`endif

endmodule

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd (both DIV_REM_BCD_EN builds).
module tb_div_result_bcd;

    localparam int W = 8;
`ifdef DIV_REM_BCD_EN
    localparam int LAT = 2 * W + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        div_ready;
    logic [7:0]  Qbus_in;
    logic [7:0]  Abus_in;
    logic [11:0] Qbcd_out;
    logic [11:0] Abcd_out;
    logic        valid;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    div_result_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .div_ready (div_ready),
        .Qbus_in   (Qbus_in),
        .Abus_in   (Abus_in),
        .Qbcd_out  (Qbcd_out),
        .Abcd_out  (Abcd_out),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        logic [7:0]  q;
        logic [7:0]  a;
        logic [11:0] qe;
        logic [11:0] ae;
    } vec_t;

    typedef struct {
        logic [11:0] q;
        logic [11:0] a;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic valid_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] rem_exp(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifndef DIV_REM_BCD_EN
        r = 12'h000;
`endif
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise ready for one cycle; the DUT sees the edge at the next clock.
    task automatic pulse(input logic [7:0] q, input logic [7:0] a,
                         input logic [11:0] qe, input logic [11:0] ae, input bit push);
        exp_t e;
        Qbus_in   = q;
        Abus_in   = a;
        div_ready = 1'b1;
        if (push) begin
            e.q   = qe;
            e.a   = rem_exp(ae);
            e.cyc = cyc + 1 + LAT;
            sb.push_back(e);
        end
        tick(1);
        div_ready = 1'b0;
        Qbus_in   = 8'($urandom);
        Abus_in   = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        tick(2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1 && valid_q === 1'b0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1, required no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("qbcd", 32'(Qbcd_out), 32'(e.q));
                chk("abcd", 32'(Abcd_out), 32'(e.a));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
        valid_q = valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'd18,  8'd3,   12'h018, 12'h003};
        tbl[1] = '{8'd6,   8'd20,  12'h006, 12'h020};
        tbl[2] = '{8'd11,  8'd6,   12'h011, 12'h006};
        tbl[3] = '{8'd255, 8'd0,   12'h255, 12'h000};
        tbl[4] = '{8'd0,   8'd255, 12'h000, 12'h255};
        tbl[5] = '{8'd99,  8'd100, 12'h099, 12'h100};
        tbl[6] = '{8'd128, 8'd209, 12'h128, 12'h209};

        rst       = 1'b1;
        div_ready = 1'b1;
        Qbus_in   = 8'd0;
        Abus_in   = 8'd0;
        tick(3);
        @(negedge clk);
        chk("rst_qbcd", 32'(Qbcd_out), 32'd0);
        chk("rst_abcd", 32'(Abcd_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(6);
        @(negedge clk);
        chk("ready_high_busy", 32'(busy), 32'd0);
        chk("ready_high_valid", 32'(valid), 32'd0);
        tick(1);
        div_ready = 1'b0;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            pulse(tbl[i].q, tbl[i].a, tbl[i].qe, tbl[i].ae, 1'b1);
            @(negedge clk);
            chk("busy_set", 32'(busy), 32'd1);
            drain();
        end

        for (int i = 0; i < 4; i++) begin
            int q;
            int a;
            q = int'($urandom_range(0, 255));
            a = int'($urandom_range(0, 255));
            tick(1);
            pulse(8'(q), 8'(a), to_bcd(q), to_bcd(a), 1'b1);
            drain();
        end
        chk("no_overrun", 32'(overrun), 32'd0);

        pulse(8'd200, 8'd17, 12'h200, 12'h017, 1'b1);
        tick(LAT);
        pulse(8'd7, 8'd250, 12'h007, 12'h250, 1'b1);
        drain();
        chk("after_done_no_overrun", 32'(overrun), 32'd0);

        pulse(8'd42, 8'd9, 12'h042, 12'h009, 1'b1);
        tick(LAT - 1);
        pulse(8'd1, 8'd2, 12'h001, 12'h002, 1'b0);
        drain();
        tick(LAT + 2);
        @(negedge clk);
        chk("done_edge_overrun", 32'(overrun), 32'd1);
        chk("done_edge_busy", 32'(busy), 32'd0);
        tick(1);

        pulse(8'd123, 8'd45, 12'h123, 12'h045, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_qbcd", 32'(Qbcd_out), 32'd0);
        chk("midrst_abcd", 32'(Abcd_out), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        tick(LAT + 2);
        pulse(8'd64, 8'd31, 12'h064, 12'h031, 1'b1);
        drain();

        pulse(8'd18, 8'd3, 12'h018, 12'h003, 1'b1);
        tick(4);
        pulse(8'd77, 8'd66, 12'h077, 12'h066, 1'b0);
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_busy", 32'(busy), 32'd1);
        drain();
        tick(LAT);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("overrun_kept_q", 32'(Qbcd_out), 32'h018);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
